// File: rtl/disp_mux_bcd_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared constants for the multiplexed seven-segment display driver:
//   - active-low glyphs {g,f,e,d,c,b,a} for codes 0-9 and A-E
//   - CODE_BLANK : digit code that lights no segment
//   - AN_OFF     : all anodes disabled (active-low)
// No ports (package).
// -----------------------------------------------------------------------------
package disp_pkg;

   typedef logic [3:0] code_t;

   localparam code_t      CODE_BLANK = 4'hF;
   localparam logic [3:0] AN_OFF     = 4'b1111;
   localparam logic [6:0] SEG_OFF    = 7'h7F;

   localparam logic [6:0] GLYPH_0 = 7'h40;
   localparam logic [6:0] GLYPH_1 = 7'h79;
   localparam logic [6:0] GLYPH_2 = 7'h24;
   localparam logic [6:0] GLYPH_3 = 7'h30;
   localparam logic [6:0] GLYPH_4 = 7'h19;
   localparam logic [6:0] GLYPH_5 = 7'h12;
   localparam logic [6:0] GLYPH_6 = 7'h02;
   localparam logic [6:0] GLYPH_7 = 7'h78;
   localparam logic [6:0] GLYPH_8 = 7'h00;
   localparam logic [6:0] GLYPH_9 = 7'h10;
   localparam logic [6:0] GLYPH_A = 7'h08;
   localparam logic [6:0] GLYPH_B = 7'h03;
   localparam logic [6:0] GLYPH_C = 7'h46;
   localparam logic [6:0] GLYPH_D = 7'h21;
   localparam logic [6:0] GLYPH_E = 7'h06;

endpackage

// File: rtl/disp_mux_bcd_sseg.sv
// -----------------------------------------------------------------------------
// bcd_to_sseg
// Purely combinational decode of a 4-bit digit code to seven active-low
// segments {g,f,e,d,c,b,a}. Codes 0-9 give decimal glyphs, A-E give hex
// glyphs, CODE_BLANK (4'hF) turns every segment off.
// Ports:
//   code  in  4  digit code
//   seg   out 7  active-low segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module bcd_to_sseg
   import disp_pkg::*;
(
   input  code_t      code,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_OFF;
      case (code)
         4'h0:    seg = GLYPH_0;
         4'h1:    seg = GLYPH_1;
         4'h2:    seg = GLYPH_2;
         4'h3:    seg = GLYPH_3;
         4'h4:    seg = GLYPH_4;
         4'h5:    seg = GLYPH_5;
         4'h6:    seg = GLYPH_6;
         4'h7:    seg = GLYPH_7;
         4'h8:    seg = GLYPH_8;
         4'h9:    seg = GLYPH_9;
         4'hA:    seg = GLYPH_A;
         4'hB:    seg = GLYPH_B;
         4'hC:    seg = GLYPH_C;
         4'hD:    seg = GLYPH_D;
         4'hE:    seg = GLYPH_E;
         default: seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/disp_mux_bcd.sv
// -----------------------------------------------------------------------------
// disp_mux_bcd
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// One digit is scanned per slot of SCAN_DIV cycles; the first BLANK_CYCLES
// cycles of each slot keep all anodes off to suppress ghosting. Each digit's
// code and dp flag are snapshotted once at the start of its slot.
//
// Optional feature: define DISP_MUX_LZB_EN to blank leading zeros at snapshot
// (digits 3..1 blank when 0 and every higher digit is 0 or blank; digit 0 is
// never blanked; dp is unaffected).
//
// Parameters:
//   SCAN_DIV      cycles per digit slot (>= 2)
//   BLANK_CYCLES  guard cycles at slot start (0 <= BLANK_CYCLES < SCAN_DIV)
// Ports:
//   clk         in   1  system clock
//   reset       in   1  synchronous active-high reset
//   in0..in3    in   4  digit codes (in0 rightmost)
//   dp_in       in   4  decimal-point request, bit k = digit k
//   an          out  4  anode enables, active-low, registered
//   sseg        out  8  segments {dp,g,f,e,d,c,b,a}, active-low, registered
//   frame_tick  out  1  one-cycle pulse when the scan wraps 3 -> 0
// -----------------------------------------------------------------------------
module disp_mux_bcd
   import disp_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] in0,
   input  logic [3:0] in1,
   input  logic [3:0] in2,
   input  logic [3:0] in3,
   input  logic [3:0] dp_in,
   output logic [3:0] an,
   output logic [7:0] sseg,
   output logic       frame_tick
);

   localparam int               CNT_W    = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] cnt;
   logic [1:0]       idx;
   code_t            code_lat;
   logic             dp_lat;

   logic [15:0] codes;
   code_t       snap_code;
   logic        snap_dp;
   code_t       code_cur;
   logic        dp_cur;
   logic [6:0]  seg;
   logic        slot_start;
   logic        slot_end;
   logic        guard;

   assign codes      = {in3, in2, in1, in0};
   assign slot_start = (cnt == '0);
   assign slot_end   = (cnt == CNT_LAST);
   assign guard      = int'(cnt) < BLANK_CYCLES;
   assign snap_dp    = dp_in[idx];

`ifdef DISP_MUX_LZB_EN
   // A digit is a leading zero when it is 0 and everything above it is
   // 0 or already blank; digit 0 always shows.
   function automatic code_t lzb_code(input logic [15:0] c, input logic [1:0] k);
      code_t d;
      logic  lead;
      d    = c[{k, 2'b00} +: 4];
      lead = 1'b1;
      for (int j = 1; j < 4; j++) begin
         if (j > int'(k))
            lead = lead & ((c[j*4 +: 4] == 4'h0) || (c[j*4 +: 4] == CODE_BLANK));
      end
      return ((k != 2'd0) && (d == 4'h0) && lead) ? CODE_BLANK : d;
   endfunction

   assign snap_code = lzb_code(codes, idx);
`else
   assign snap_code = codes[{idx, 2'b00} +: 4];
`endif

   // In the snapshot cycle the latch is still loading, so decode the value
   // being captured; otherwise a zero-guard slot would flash the previous
   // digit's glyph for one cycle under the new anode.
   assign code_cur = slot_start ? snap_code : code_lat;
   assign dp_cur   = slot_start ? snap_dp   : dp_lat;

   bcd_to_sseg u_dec (
      .code (code_cur),
      .seg  (seg)
   );

   // Scan state, snapshot latch and output registers (one cycle behind state).
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= '0;
         idx        <= 2'd0;
         code_lat   <= CODE_BLANK;
         dp_lat     <= 1'b0;
         an         <= AN_OFF;
         sseg       <= 8'hFF;
         frame_tick <= 1'b0;
      end else begin
         cnt <= slot_end ? '0 : cnt + 1'b1;
         if (slot_end)
            idx <= idx + 2'd1;
         if (slot_start) begin
            code_lat <= snap_code;
            dp_lat   <= snap_dp;
         end
         an         <= guard ? AN_OFF : ~(4'b0001 << idx);
         sseg       <= {~dp_cur, seg};
         frame_tick <= slot_end && (idx == 2'd3);
      end
   end

endmodule

// File: tb/tb_disp_mux_bcd.sv
module tb_disp_mux_bcd;

   localparam int SD = 8;
   localparam int BC = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [3:0] in0, in1, in2, in3, dp_in;
   logic [3:0] an_a, an_b;
   logic [7:0] sseg_a, sseg_b;
   logic       ft_a, ft_b;

   disp_mux_bcd #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) u_dut_a (
      .clk(clk), .reset(reset), .in0(in0), .in1(in1), .in2(in2), .in3(in3),
      .dp_in(dp_in), .an(an_a), .sseg(sseg_a), .frame_tick(ft_a)
   );

   disp_mux_bcd #(.SCAN_DIV(SD), .BLANK_CYCLES(0)) u_dut_b (
      .clk(clk), .reset(reset), .in0(in0), .in1(in1), .in2(in2), .in3(in3),
      .dp_in(dp_in), .an(an_b), .sseg(sseg_b), .frame_tick(ft_b)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state: n counts post-reset edges; slot/digit/position
   // follow from plain division of n.
   int         n        = 0;
   int         last_n   = -1;
   bit         model_ok = 1'b0;
   int         ft_count = 0;
   logic [3:0] snap_c   = 4'hF;
   logic       snap_d   = 1'b0;
   logic [3:0] e_an_a, e_an_b;
   logic [7:0] e_sseg;
   logic       e_ft;

   typedef struct {
      logic [15:0] codes;   // {in3,in2,in1,in0}
      logic [3:0]  dp;
      logic [31:0] exp;     // expected sseg {d3,d2,d1,d0}
   } vec_t;
   vec_t tbl[7];

   function automatic logic [7:0] glyph(input logic [3:0] c);
      case (c)
         4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;
         4'h3: return 8'hB0;  4'h4: return 8'h99;  4'h5: return 8'h92;
         4'h6: return 8'h82;  4'h7: return 8'hF8;  4'h8: return 8'h80;
         4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
         4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic [3:0] model_code(input logic [15:0] c, input int k);
`ifdef DISP_MUX_LZB_EN
      bit all_lead;
      if (k != 0 && c[k*4 +: 4] == 4'h0) begin
         all_lead = 1'b1;
         for (int j = k + 1; j < 4; j++)
            if (!(c[j*4 +: 4] == 4'h0 || c[j*4 +: 4] == 4'hF)) all_lead = 1'b0;
         if (all_lead) return 4'hF;
      end
`endif
      return c[k*4 +: 4];
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (n=%0d, t=%0t)", name, act, exp, last_n, $time);
      end
   endtask

   task automatic set_inputs(input logic [15:0] c, input logic [3:0] d);
      {in3, in2, in1, in0} = c;
      dp_in = d;
   endtask

   task automatic cycle();
      logic [15:0] c;
      int pos, dig;
      @(posedge clk);
      c = {in3, in2, in1, in0};
      if (reset) begin
         e_an_a = 4'hF; e_an_b = 4'hF; e_sseg = 8'hFF; e_ft = 1'b0;
         n = 0; last_n = -1; model_ok = 1'b1;
      end else if (model_ok) begin
         pos = n % SD;
         dig = (n / SD) % 4;
         if (pos == 0) begin
            snap_c = model_code(c, dig);
            snap_d = dp_in[dig];
         end
         e_an_a = (pos < BC) ? 4'hF : ~(4'b0001 << dig);
         e_an_b = ~(4'b0001 << dig);
         e_sseg = glyph(snap_c) & (snap_d ? 8'h7F : 8'hFF);
         e_ft   = (pos == SD - 1) && (dig == 3);
         last_n = n;
         n++;
      end
      #1;
      if (model_ok) begin
         chk("an_a", 8'(an_a), 8'(e_an_a));
         chk("sseg_a", sseg_a, e_sseg);
         chk("ft_a", 8'(ft_a), 8'(e_ft));
         chk("an_b", 8'(an_b), 8'(e_an_b));
         chk("sseg_b", sseg_b, e_sseg);
         chk("ft_b", 8'(ft_b), 8'(e_ft));
         chk("an_b_onehot", 8'($countones(~an_b) <= 1), 8'd1);
      end
      if (ft_a === 1'b1) ft_count++;
   endtask

   initial begin
      tbl[0] = '{16'h4321, 4'b0000, 32'h99B0A4F9};
      tbl[1] = '{16'hF321, 4'b0100, 32'hFF30A4F9};
      tbl[2] = '{16'hEDCB, 4'b1111, 32'h06214603};
      tbl[3] = '{16'h9876, 4'b0001, 32'h9080F802};
`ifdef DISP_MUX_LZB_EN
      tbl[4] = '{16'h0050, 4'b0000, 32'hFFFF92C0};
      tbl[5] = '{16'h000A, 4'b1000, 32'h7FFFFF88};
      tbl[6] = '{16'h0F0F, 4'b0000, 32'hFFFFFFFF};
`else
      tbl[4] = '{16'h0050, 4'b0000, 32'hC0C092C0};
      tbl[5] = '{16'h000A, 4'b1000, 32'h40C0C088};
      tbl[6] = '{16'h0F0F, 4'b0000, 32'hC0FFC0FF};
`endif

      reset = 1'b1;
      set_inputs(16'h0000, 4'h0);
      cycle();
      cycle();

      // Table vectors: one full frame per entry, glyph checked mid-slot.
      for (int i = 0; i < 7; i++) begin
         set_inputs(tbl[i].codes, tbl[i].dp);
         reset = 1'b1;
         cycle();
         reset = 1'b0;
         ft_count = 0;
         for (int k = 0; k < 34; k++) begin
            cycle();
            if (last_n % SD == 4)
               chk($sformatf("tbl%0d_digit%0d", i, last_n / SD), sseg_a,
                   tbl[i].exp[(last_n / SD) * 8 +: 8]);
         end
         chk($sformatf("tbl%0d_frame_ticks", i), 8'(ft_count), 8'd1);
      end

      // Mid-slot input change is held until the digit's next slot.
      set_inputs(16'h4321, 4'b0000);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      for (int k = 0; k < 12; k++) cycle();
      in1 = 4'h7;
      cycle();
      chk("hold_old_digit1", sseg_a, 8'hA4);
      for (int k = 0; k < 32; k++) cycle();
      chk("new_digit1", sseg_a, 8'hF8);

      // Reset mid digit-2 slot, then full-timing restart at digit 0.
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      for (int k = 0; k < 20; k++) cycle();
      reset = 1'b1;
      cycle();
      chk("midrst_an", 8'(an_a), 8'h0F);
      chk("midrst_sseg", sseg_a, 8'hFF);
      chk("midrst_ft", 8'(ft_a), 8'h00);
      reset = 1'b0;
      cycle();
      cycle();
      chk("resume_guard", 8'(an_a), 8'h0F);
      cycle();
      chk("resume_digit0", 8'(an_a), 8'h0E);
      for (int k = 0; k < 40; k++) cycle();

      // Randomized traffic with occasional resets against the model.
      for (int k = 0; k < 800; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 4))
               0: in0 = 4'($urandom_range(0, 15));
               1: in1 = 4'($urandom_range(0, 15));
               2: in2 = 4'($urandom_range(0, 15));
               3: in3 = 4'($urandom_range(0, 15));
               default: dp_in = 4'($urandom_range(0, 15));
            endcase
         end
         if ($urandom_range(0, 9) == 0) begin
            // bias toward zeros so leading-zero cases occur often
            {in3, in2} = 8'h00;
         end
         reset = ($urandom_range(0, 199) == 0);
         cycle();
      end
      reset = 1'b0;
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/disp_mux_bcd.md
# disp_mux_bcd

Time-multiplexed driver for a 4-digit common-anode seven-segment display, downstream of the cascaded-BCD stopwatch. It takes four 4-bit digit codes and four decimal-point flags, scans one digit at a time, and drives active-low anodes and segments. A guard interval between digits suppresses ghosting. Each digit code is snapshotted once per slot, so a digit never changes mid-slot while the stopwatch counts.

## Interface
- `SCAN_DIV`, default 50000: clock cycles per digit slot; legal range ≥ 2.
- `BLANK_CYCLES`, default 500: guard cycles at the start of each slot with all anodes off; legal range 0 ≤ BLANK_CYCLES < SCAN_DIV.
- `clk`  in  1  system clock, single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `in0`  in  4  digit 0 code (rightmost; stopwatch ones).
- `in1`  in  4  digit 1 code (stopwatch tens).
- `in2`  in  4  digit 2 code (stopwatch hundreds).
- `in3`  in  4  digit 3 code; tie to 4'hF for blank.
- `dp_in`  in  4  decimal-point request per digit; bit k is digit k, active-high.
- `an`  out  4  anode enables, active-low, at most one bit low at a time.
- `sseg`  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.
- `frame_tick`  out  1  one-cycle pulse each time the scan wraps from digit 3 to digit 0.

## Operation
- State:
  - slot counter `cnt`, 0..SCAN_DIV-1; width is clog2(SCAN_DIV).
  - digit index `idx`, 0..3.
  - 4-bit code latch and 1-bit dp latch.
- Scan sequence:
  - `cnt` increments every cycle and wraps to 0 at SCAN_DIV-1.
  - When `cnt` wraps, `idx` advances 0→1→2→3→0.
- Snapshot: in the cycle where `cnt`==0, the block latches in[idx] and dp_in[idx] for the current slot. The latch holds for the rest of the slot.
- Code decode:
  - 0–9 map to decimal glyphs.
  - A, b, C, d, E map to hex glyphs.
  - 4'hF is blank: segments a–g all off.
- Segment output: dp segment = latched dp (inverted for active-low); it is independent of blanking.
- Anode output:
  - Slot positions `cnt` < BLANK_CYCLES: `an`=4'b1111.
  - Remaining positions: an[idx]=0, all other bits 1.
- `frame_tick` is asserted for the cycle following `cnt`==SCAN_DIV-1 with `idx`==3.
- Input changes during a slot are ignored until that digit's next snapshot. Worst-case display latency is 4·SCAN_DIV+1 cycles.

## Timing
- Output registers: `an`, `sseg` and `frame_tick` are registered, one cycle behind the `cnt`/`idx` state they reflect.
- Reset (synchronous; takes effect at the clock edge where `reset`=1):
  - `an`=4'b1111, `sseg`=8'hFF, `frame_tick`=0.
  - `cnt`=0, `idx`=0, latches cleared to blank.
- After reset: first cycle with `reset`=0 is `cnt`=0 for digit 0, so the snapshot happens then.
  - With BLANK_CYCLES=0, an=4'b1110 appears one cycle after that edge.
  - Otherwise an=4'b1110 appears BLANK_CYCLES+1 cycles after that edge.
- Reset mid-slot: scan restarts at digit 0 with `cnt`=0; no partial frame_tick.
- Simultaneous input change at the snapshot cycle: the value present at that edge is captured.
- BLANK_CYCLES=0: no guard interval; anodes switch directly between adjacent digits.
- Anode overlap never occurs: the old anode goes high in the same cycle the new slot's state is registered.

## Configuration
- Macro: `DISP_MUX_LZB_EN`.
- Defined: leading-zero blanking is applied at snapshot.
  - Digit k (k = 3, 2, 1) is forced blank when its code is 0 and every higher digit is 0 or blank.
  - Digit 0 is never blanked.
  - dp is unaffected: a blanked digit still shows its requested dp.
- Not defined: zeros are always displayed; codes pass through unchanged.

## Structure
- Package `disp_pkg` holds:
  - the active-low glyph constants for 0–9 and A–E;
  - `CODE_BLANK` = 4'hF;
  - `AN_OFF` = 4'b1111.
- Sub-module `bcd_to_sseg`: purely combinational decode of 4-bit code to 7 active-low segments. It is instantiated once on the latched code.

## Test plan
Benches use SCAN_DIV=8 and BLANK_CYCLES=2.
- Reset then release; in0..in3=1,2,3,4; dp_in=0:
  - an sequence: 1111×3, 1110×6 with sseg=8'hF9, then 1111×2, 1101×6 with sseg=8'hA4, and so on.
  - frame_tick pulses once per 32 cycles.
- Change in1 from 2 to 7 while digit 1 is lit: current slot still shows 2; the next digit-1 slot shows 7 (sseg=8'hF8).
- in3=4'hF and dp_in=4'b0100: digit 3 shows sseg=8'hFF; digit 2 shows its glyph with sseg[7]=0.
- `DISP_MUX_LZB_EN` defined; in3..in0 = 0,0,5,0: digits 3 and 2 show 8'hFF; digit 1 shows 8'h92; digit 0 shows 8'hC0. Without the macro, digits 3 and 2 show 8'hC0.
- Assert `reset` for one cycle mid digit-2 slot: next edge gives an=1111 and sseg=FF; the scan resumes at digit 0 with full timing.
- BLANK_CYCLES=0 run: at no cycle does `an` have more than one bit low; there are no all-off cycles after the reset recovery.
